ppu_frame_writer: RTL
=====================

// Module: ppu_frame_writer
// PURPOSE
//  Pixel sink directly downstream of the PPU pixel mixer. Accepts 2-bit colour indices (px_in/px_valid)
//  plus the PPU mode, maps them through BGP to shades, and writes them into a double-buffered
//  160x144 2-bit framebuffer. The display side reads the completed bank through a 1-cycle-latency port.
//  Banks swap at V-blank entry so the display never reads a half-drawn frame.
// PARAMETERS
//  H_PIX     160  visible pixels per line; later pixels on a line are dropped
//  V_PIX     144  visible lines per frame; pixels on later lines are dropped
//  ADDR_W    15   framebuffer address width (must satisfy 2**ADDR_W >= H_PIX*V_PIX)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset: synchronous, active-high
//  lcd_on     in   1       LCDC[7]; 0 = LCD off
//  ppu_mode   in   2       PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
//  px_in      in   2       colour index from PPU mixer
//  px_valid   in   1       px_in valid this cycle
//  bgp        in   8       BG palette (FF47); shade(i) = bgp[2i+1:2i]
//  rd_addr    in   ADDR_W  display read address (y*H_PIX + x), sampled every cycle
//  rd_data    out  2       shade at rd_addr from the display bank, 1 cycle later
//  disp_bank  out  1       bank currently being displayed
//  frame_done out  1       1-cycle pulse when a bank swap occurs
//  overflow   out  1       sticky: a pixel was dropped (x>=H_PIX or y>=V_PIX); cleared on rst only
// BEHAVIOUR
//  Reset: FSM=SYNC, x=0, y=0, line_base=0, wr_bank=1, disp_bank=0, rd_data=0, frame_done=0,
//   overflow=0, no write pending. Reset mid-line aborts the pending write; the RAM is not cleared.
//  FSM (evaluated every cycle; mode edges detected against ppu_mode registered the previous cycle):
//   SYNC    : ignore pixels; on ppu_mode==V_BLANK -> VBLANK (no swap, no pulse).
//   VBLANK  : on ppu_mode leaving V_BLANK -> LINE_WAIT with y=0, line_base=0.
//   LINE_WAIT: on ppu_mode==DRAW -> DRAWING with x=0. On V_BLANK entry -> VBLANK with swap.
//   DRAWING : each px_valid: if x<H_PIX and y<V_PIX write, else set overflow; x++ (saturate at 255).
//             On ppu_mode leaving DRAW -> LINE_WAIT; y++, line_base += H_PIX (no wrap; y>=V_PIX drops).
//   Swap (V_BLANK entry from LINE_WAIT or DRAWING): wr_bank<=~wr_bank, disp_bank<=~disp_bank,
//    frame_done=1 for exactly one cycle.
//  lcd_on==0 in any state -> SYNC, no write, no swap, outputs hold; resumes at next V_BLANK.
//  Write pipeline: stage 0 registers {wr_bank, line_base+x, bgp-mapped shade}; stage 1 writes RAM.
//   The palette is sampled at the px_valid cycle (mid-line BGP writes take effect on the next pixel).
//  Simultaneous px_valid and DRAW exit in the same cycle: the pixel is accepted (written at current
//   x,y) before y advances.
//  Read: rd_data <= ram[disp_bank][rd_addr] registered; latency exactly 1. A read from the display
//   bank never collides with a write (writes target wr_bank only). Reads to rd_addr >= H_PIX*V_PIX
//   return 0.
//  Address arithmetic is unsigned: line_base+x is ADDR_W bits and never exceeds H_PIX*V_PIX-1 when written.
// STRUCTURE
//  ppu_pkg (shared): PPU_STATES_t (move from file scope), H_PIX/V_PIX defaults, fw_state_t
//   {FW_SYNC, FW_VBLANK, FW_LINE_WAIT, FW_DRAWING}.
//  Sub-module fb_dpram: simple dual-port RAM of 2*H_PIX*V_PIX x 2 bits (address {bank,addr}),
//   1 write port and 1 registered read port; infers M10K on the DE1-SoC.
//  ppu_frame_writer holds the FSM, x/y/line_base counters, palette map and the write pipeline.
// TESTING
//  1 Reset, ppu_mode=DRAW with 8 px_valid -> no writes (SYNC), overflow=0, disp_bank=0.
//  2 Sync via V_BLANK; line 0: px 0,1,2,3 with bgp=8'hE4 -> after swap rd_addr 0..3 give 0,1,2,3;
//    with bgp=8'h1B the same pixels give 3,2,1,0.
//  3 Full frame 144x160 of px=y[1:0]; V_BLANK entry -> frame_done pulses once, disp_bank=1;
//    rd_addr=160*5+7 -> rd_data=1 one cycle later.
//  4 Line with 168 px_valid -> pixels 160..167 dropped, overflow=1, rd_addr 160 (line 1, x=0) unchanged.
//  5 px_valid in the same cycle that ppu_mode goes DRAW->H_BLANK -> pixel written at (x,y); the next
//    line starts at line_base+160, x=0.
//  6 Reset asserted mid-line (x=80) -> next cycle all outputs at reset values; no write follows.

Source files
------------

// File: rtl/ppu_frame_writer_pkg.sv
// ppu_frame_writer_pkg: PPU mode encoding, frame writer states, framebuffer geometry and palette map.
package ppu_frame_writer_pkg;
   typedef enum logic [1:0] {H_BLANK = 2'd0, V_BLANK = 2'd1, SCAN = 2'd2, DRAW = 2'd3} PPU_STATES_t;
   typedef enum logic [1:0] {FW_SYNC, FW_VBLANK, FW_LINE_WAIT, FW_DRAWING} fw_state_t;
   localparam int FB_H_PIX = 160;
   localparam int FB_V_PIX = 144;
   localparam int FB_ADDR_W = 15;
   function automatic logic [1:0] shade(input logic [7:0] bgp, input logic [1:0] idx);
      return bgp[{idx, 1'b0} +: 2];
   endfunction
endpackage

// File: rtl/ppu_frame_writer_if.sv
// ppu_frame_writer_if: pixel input, palette and display read port of the frame writer.
interface ppu_frame_writer_if import ppu_frame_writer_pkg::*; #(parameter int ADDR_W = FB_ADDR_W);
   logic lcd_on;
   PPU_STATES_t ppu_mode;
   logic [1:0] px_in;
   logic px_valid;
   logic [7:0] bgp;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0] rd_data;
   logic disp_bank;
   logic frame_done;
   logic overflow;
   modport master(output lcd_on, ppu_mode, px_in, px_valid, bgp, rd_addr,
                  input rd_data, disp_bank, frame_done, overflow);
   modport slave(input lcd_on, ppu_mode, px_in, px_valid, bgp, rd_addr,
                 output rd_data, disp_bank, frame_done, overflow);
endinterface

// File: rtl/ppu_frame_writer_fb_dpram.sv
// fb_dpram: two-bank 2-bit framebuffer, one write port and one registered read port.
module fb_dpram #(
   parameter int DEPTH = 23040,
   parameter int ADDR_W = 15
) (
   input logic clk,
   input logic we,
   input logic wbank,
   input logic [ADDR_W-1:0] waddr,
   input logic [1:0] wdata,
   input logic rbank,
   input logic [ADDR_W-1:0] raddr,
   output logic [1:0] rdata
);
   logic [1:0] mem [2*DEPTH];
   logic [ADDR_W:0] widx, ridx;
   // banks are packed back to back so the array is exactly two frames deep
   assign widx = (wbank ? (ADDR_W+1)'(DEPTH) : '0) + {1'b0, waddr};
   assign ridx = (rbank ? (ADDR_W+1)'(DEPTH) : '0) + {1'b0, raddr};
   always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdata;
      rdata <= mem[ridx];
   end
endmodule

// File: rtl/ppu_frame_writer.sv
// ppu_frame_writer: maps PPU pixels through BGP into a double-buffered framebuffer,
// swapping banks at V-blank entry so the display only ever sees complete frames.
module ppu_frame_writer import ppu_frame_writer_pkg::*; #(
   parameter int H_PIX = FB_H_PIX,
   parameter int V_PIX = FB_V_PIX,
   parameter int ADDR_W = FB_ADDR_W
) (
   input logic clk,
   input logic rst,
   ppu_frame_writer_if.slave bus
);
   fw_state_t state_q, state_d;
   PPU_STATES_t mode_q;
   logic [7:0] x, y;
   logic [ADDR_W-1:0] line_base, wr_addr;
   logic [1:0] wr_shade, ram_q;
   logic wr_bank, wr_bank_q, wr_v, rd_ok;
   logic accept, in_range, swap, new_frame, line_start, line_end, vb_entry;
   assign vb_entry = bus.ppu_mode == V_BLANK && mode_q != V_BLANK;
   assign in_range = int'(x) < H_PIX && int'(y) < V_PIX;
   always_comb begin
      state_d = state_q;
      accept = 1'b0;
      swap = 1'b0;
      new_frame = 1'b0;
      line_start = 1'b0;
      line_end = 1'b0;
      if (!bus.lcd_on) state_d = FW_SYNC;
      else case (state_q)
         FW_SYNC: state_d = bus.ppu_mode == V_BLANK ? FW_VBLANK : FW_SYNC;
         FW_VBLANK: begin
            new_frame = bus.ppu_mode != V_BLANK;
            state_d = new_frame ? FW_LINE_WAIT : FW_VBLANK;
         end
         FW_LINE_WAIT: begin
            swap = vb_entry;
            line_start = !vb_entry && bus.ppu_mode == DRAW;
            state_d = swap ? FW_VBLANK : line_start ? FW_DRAWING : FW_LINE_WAIT;
         end
         FW_DRAWING: begin
            // a pixel arriving with the DRAW exit still lands on the current line
            accept = bus.px_valid;
            swap = vb_entry;
            line_end = !vb_entry && bus.ppu_mode != DRAW;
            state_d = swap ? FW_VBLANK : line_end ? FW_LINE_WAIT : FW_DRAWING;
         end
         default: state_d = FW_SYNC;
      endcase
   end
   always_ff @(posedge clk) state_q <= rst ? FW_SYNC : state_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= H_BLANK;
         x <= '0;
         y <= '0;
         line_base <= '0;
         wr_bank <= 1'b1;
         bus.disp_bank <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.overflow <= 1'b0;
         wr_v <= 1'b0;
         wr_bank_q <= 1'b0;
         wr_addr <= '0;
         wr_shade <= '0;
         rd_ok <= 1'b0;
      end else begin
         mode_q <= bus.ppu_mode;
         if (new_frame) begin
            y <= '0;
            line_base <= '0;
         end
         if (line_start) x <= '0;
         if (line_end) begin
            y <= y == 8'hFF ? y : y + 8'd1;
            line_base <= line_base + ADDR_W'(H_PIX);
         end
         if (accept) begin
            x <= x == 8'hFF ? x : x + 8'd1;
            bus.overflow <= bus.overflow | ~in_range;
         end
         wr_v <= accept && in_range;
         wr_bank_q <= wr_bank;
         wr_addr <= line_base + ADDR_W'(x);
         wr_shade <= shade(bus.bgp, bus.px_in);
         if (swap) begin
            wr_bank <= ~wr_bank;
            bus.disp_bank <= ~bus.disp_bank;
         end
         bus.frame_done <= swap;
         rd_ok <= int'(bus.rd_addr) < H_PIX * V_PIX;
      end
   end
   // reset also suppresses the write already sitting in the pipeline
   fb_dpram #(.DEPTH(H_PIX * V_PIX), .ADDR_W(ADDR_W)) u_ram (
      .clk(clk),
      .we(wr_v & ~rst),
      .wbank(wr_bank_q),
      .waddr(wr_addr),
      .wdata(wr_shade),
      .rbank(bus.disp_bank),
      .raddr(bus.rd_addr),
      .rdata(ram_q)
   );
   assign bus.rd_data = rd_ok ? ram_q : 2'd0;
endmodule
